// File: rtl/lat_unroll_param.sv
// -----------------------------------------------------------------------------
// lat_unroll_param
//
// Loop address table plus unroll controller for the wide fetch front end.
// It sits between IF and the loop interpreter. A predicted-taken backward
// branch in a fetch group starts training. The body is then measured group by
// group, and a table entry {start, ft, unroll} is written. The entry is
// implied valid when its bit in tbl_vld is set. A later fetch group whose
// lane-0 PC equals a valid start address dispatches the body `unroll` times
// into the loop buffer. Fetch then stalls until a misprediction flush
// releases it.
//
// Optional feature (compile-time macro): LAT_INVALIDATE_EN
//   When defined, a mispredict taken while in DISPATCH invalidates the entry
//   being dispatched. Without it, entries are only ever replaced by training.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   pc_in           fetch-group PCs; lane i at [(LANES-1-i)*AW +: AW], lane 0 oldest
//   fetch_vld_in    fetch group valid; all state holds while low
//   bck_lp_in       bit i: lane i is a predicted-taken backward branch
//   bck_tgt_in      target of the lowest-index flagged backward branch
//   mis_pred_in     misprediction flush; returns to IDLE, overrides everything
//   state_out       IDLE=00, TRAIN=01, DISPATCH=10, STALL=11
//   loop_strt_out   table hit this cycle (combinational)
//   fnsh_unrll_out  last unrolled iteration dispatched (one-cycle pulse)
//   stll_ftch_out   stall IF (high in STALL)
//   inst_valid_out  per-lane valid, MSB = lane 0
//   hit_idx_out     index of the hit entry, captured when dispatch starts
// -----------------------------------------------------------------------------
module lat_unroll_param #(
    parameter int LANES     = 4,
    parameter int ENTRIES   = 4,
    parameter int AW        = 16,
    parameter int BUF_INSTS = 64,
    parameter int CW        = $clog2(BUF_INSTS) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*AW-1:0]        pc_in,
    input  logic                       fetch_vld_in,
    input  logic [LANES-1:0]           bck_lp_in,
    input  logic [AW-1:0]              bck_tgt_in,
    input  logic                       mis_pred_in,
    output logic [1:0]                 state_out,
    output logic                       loop_strt_out,
    output logic                       fnsh_unrll_out,
    output logic                       stll_ftch_out,
    output logic [LANES-1:0]           inst_valid_out,
    output logic [$clog2(ENTRIES)-1:0] hit_idx_out
);

    localparam int IW = $clog2(ENTRIES);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] BUF_C   = CW'(BUF_INSTS);

`ifdef LAT_INVALIDATE_EN
    localparam bit INVALIDATE_EN = 1'b1;
`else
    localparam bit INVALIDATE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        TRAIN    = 2'b01,
        DISPATCH = 2'b10,
        STALL    = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t        state;

    // Table. The body size is only needed to derive the unroll factor, so the
    // entry keeps the derived unroll value rather than the raw count.
    logic [ENTRIES-1:0] tbl_vld;
    logic [AW-1:0]      tbl_start  [ENTRIES];
    logic [AW-1:0]      tbl_ft     [ENTRIES];
    logic [CW-1:0]      tbl_unroll [ENTRIES];
    logic [IW-1:0]      rr_ptr;

    // Training capture
    logic [AW-1:0]      tr_start;
    logic [AW-1:0]      tr_ft;
    logic [CW-1:0]      tr_cnt;
    logic               tr_first;     // next valid group is the first body group

    // Shared by TRAIN and DISPATCH: PC of the loop's backward branch (ft-1)
    logic [AW-1:0]      last_pc;

    // Dispatch progress
    logic [CW-1:0]      unroll_cnt;
    logic [CW-1:0]      buf_cnt;
    logic [IW-1:0]      hit_idx;

    // -------------------------------------------------------------------------
    // Lane PCs
    // -------------------------------------------------------------------------
    logic [AW-1:0] lane_pc [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_pc[g] = pc_in[(LANES-1-g)*AW +: AW];
    end

    // Ceiling log2 of a non-zero body size.
    function automatic logic [CW-1:0] ceil_log2(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < CW; i++) begin
            if ((CW'(1) << i) < v) r = CW'(i + 1);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Table lookup: lowest matching valid entry wins
    // -------------------------------------------------------------------------
    logic          match;
    logic [IW-1:0] hit_sel;
    logic          hit;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch is inferred; iterating from the
    // top index down lets the lowest match overwrite the others.
    always_comb begin
        match   = 1'b0;
        hit_sel = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (tbl_vld[e] && (tbl_start[e] == lane_pc[0])) begin
                match   = 1'b1;
                hit_sel = IW'(e);
            end
        end
    end

    assign hit = match && (state == IDLE) && fetch_vld_in && !rst;

    // -------------------------------------------------------------------------
    // Lowest flagged backward branch
    // -------------------------------------------------------------------------
    logic          bck_found;
    logic [LW-1:0] bck_lane;

    always_comb begin
        bck_found = 1'b0;
        bck_lane  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (bck_lp_in[i]) begin
                bck_found = 1'b1;
                bck_lane  = LW'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // End lane: lowest lane holding the active branch PC
    // -------------------------------------------------------------------------
    logic          end_found;
    logic [LW-1:0] end_k;

    always_comb begin
        end_found = 1'b0;
        end_k     = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_pc[i] == last_pc) begin
                end_found = 1'b1;
                end_k     = LW'(i);
            end
        end
    end

    // Instructions of the loop body contained in this group
    logic [CW-1:0] step;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] buf_next;
    logic [CW-1:0] unroll_new;
    logic          train_ovf;
    logic          buf_ovf;
    logic          first_bad;

    assign step       = end_found ? (CW'(end_k) + CW'(1)) : LANES_C;
    assign cnt_next   = tr_cnt + step;
    assign buf_next   = buf_cnt + step;
    assign train_ovf  = cnt_next > BUF_C;
    assign buf_ovf    = buf_next > BUF_C;
    assign first_bad  = tr_first && (lane_pc[0] != tr_start);
    assign unroll_new = BUF_C >> ceil_log2(cnt_next);

    // -------------------------------------------------------------------------
    // Victim selection: lowest invalid entry, else the round-robin pointer
    // -------------------------------------------------------------------------
    logic          all_valid;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] victim;

    always_comb begin
        free_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (!tbl_vld[e]) free_idx = IW'(e);
        end
    end

    assign all_valid = &tbl_vld;
    assign victim    = all_valid ? rr_ptr : free_idx;

    // A training group that closes the body writes the table unless flushed
    logic tbl_we;

    assign tbl_we = (state == TRAIN) && fetch_vld_in && !mis_pred_in &&
                    !first_bad && !train_ovf && end_found;

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    // NOTE: all sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tbl_vld    <= '0;
            rr_ptr     <= '0;
            tr_start   <= '0;
            tr_ft      <= '0;
            tr_cnt     <= '0;
            tr_first   <= 1'b0;
            last_pc    <= '0;
            unroll_cnt <= '0;
            buf_cnt    <= '0;
            hit_idx    <= '0;
        end else if (mis_pred_in) begin
            // The flush wins over any transition or write due this cycle.
            state <= IDLE;
            if (INVALIDATE_EN && (state == DISPATCH)) begin
                tbl_vld[hit_idx] <= 1'b0;
            end
        end else if (fetch_vld_in) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state      <= DISPATCH;
                        unroll_cnt <= tbl_unroll[hit_sel];
                        buf_cnt    <= '0;
                        hit_idx    <= hit_sel;
                        last_pc    <= tbl_ft[hit_sel] - AW'(1);
                    end else if (bck_found) begin
                        state    <= TRAIN;
                        tr_start <= bck_tgt_in;
                        tr_ft    <= lane_pc[bck_lane] + AW'(1);
                        last_pc  <= lane_pc[bck_lane];
                        tr_cnt   <= '0;
                        tr_first <= 1'b1;
                    end
                end

                TRAIN: begin
                    tr_first <= 1'b0;
                    if (first_bad || train_ovf) begin
                        state <= IDLE;
                    end else begin
                        tr_cnt <= cnt_next;
                        if (end_found) begin
                            state           <= IDLE;
                            tbl_vld[victim] <= 1'b1;
                            // Filling a free slot leaves the pointer alone.
                            if (all_valid) rr_ptr <= rr_ptr + IW'(1);
                        end
                    end
                end

                DISPATCH: begin
                    if (buf_ovf) begin
                        state <= IDLE;
                    end else begin
                        buf_cnt <= buf_next;
                        if (end_found) begin
                            unroll_cnt <= unroll_cnt - CW'(1);
                            if (unroll_cnt == CW'(1)) state <= STALL;
                        end
                    end
                end

                STALL: begin
                    // Held until a mispredict flush.
                end
            endcase
        end
    end

    // NOTE: the payload array has no reset; a slot is never read as a hit
    // until its valid bit is set, so only tbl_vld is cleared on reset.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_start[victim]  <= tr_start;
            tbl_ft[victim]     <= tr_ft;
            tbl_unroll[victim] <= unroll_new;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic [LANES-1:0] end_mask;

    // k+1 ones starting from the MSB (lane 0)
    always_comb begin
        end_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            end_mask[LANES-1-i] = (i <= int'(end_k));
        end
    end

    always_comb begin
        case (state)
            STALL:    inst_valid_out = '0;
            DISPATCH: inst_valid_out = end_found ? end_mask : '1;
            default:  inst_valid_out = '1;
        endcase
    end

    assign state_out      = state;
    assign loop_strt_out  = hit;
    assign fnsh_unrll_out = (state == DISPATCH) && fetch_vld_in && !mis_pred_in &&
                            end_found && !buf_ovf && (unroll_cnt == CW'(1));
    assign stll_ftch_out  = (state == STALL);
    assign hit_idx_out    = hit_idx;

endmodule
